// File: rtl/mips_pkg.sv
// Shared forwarding-select encodings for the MIPS pipeline forwarding/hazard logic.
package mips_pkg;

  typedef logic [1:0] fwd_sel_t;

  // EX-stage ALU operand mux encodings
  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

  // ID-stage branch comparator mux encodings
  localparam fwd_sel_t CMP_RF    = 2'b00;
  localparam fwd_sel_t CMP_EXMEM = 2'b01;
  localparam fwd_sel_t CMP_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_src_match.sv
// Per-source producer matching: flags against ID/EX, EX/MEM, MEM/WB and the
// resulting next ALU forward select and current comparator select.
module fwd_src_match
  import mips_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0] i_src,
  input  logic          i_used,
  input  logic          i_id_ex_reg_write,
  input  logic [AW-1:0] i_id_ex_dest,
  input  logic          i_ex_mem_reg_write,
  input  logic          i_ex_mem_mem_read,
  input  logic [AW-1:0] i_ex_mem_dest,
  input  logic          i_mem_wb_reg_write,
  input  logic [AW-1:0] i_mem_wb_dest,
  output logic          o_m_id_ex,
  output logic          o_m_ex_mem,
  output logic          o_m_mem_wb,
  output fwd_sel_t      o_alu_sel_nxt,
  output fwd_sel_t      o_cmp_sel
);

  // r0 is hardwired zero, so a write to it is never a real producer
  assign o_m_id_ex  = i_id_ex_reg_write  && (i_id_ex_dest  != '0) && (i_id_ex_dest  == i_src) && i_used;
  assign o_m_ex_mem = i_ex_mem_reg_write && (i_ex_mem_dest != '0) && (i_ex_mem_dest == i_src) && i_used;
  assign o_m_mem_wb = i_mem_wb_reg_write && (i_mem_wb_dest != '0) && (i_mem_wb_dest == i_src) && i_used;

  // ALU selects are for next cycle: the ID/EX producer will sit in EX/MEM,
  // the EX/MEM producer in MEM/WB. A current MEM/WB producer is covered by
  // the write-through regfile.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_alu_sel_nxt = FWD_RF;
    o_cmp_sel     = CMP_RF;
    if (o_m_id_ex)       o_alu_sel_nxt = FWD_EXMEM;
    else if (o_m_ex_mem) o_alu_sel_nxt = FWD_MEMWB;
    // A load in EX/MEM has no data yet; that case is stalled at the top level.
    if (o_m_ex_mem && !i_ex_mem_mem_read) o_cmp_sel = CMP_EXMEM;
    else if (o_m_mem_wb)                  o_cmp_sel = CMP_MEMWB;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + hazard unit: registered EX ALU selects, combinational ID branch
// comparator selects, load-use / branch stall detection and a stall counter.
module fwd_hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned AW      = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]     id_src_used,
  input  logic                   id_is_branch,
  input  logic                   flush,
  input  logic                   id_ex_reg_write,
  input  logic                   id_ex_mem_read,
  input  logic [AW-1:0]          id_ex_dest,
  input  logic                   ex_mem_reg_write,
  input  logic                   ex_mem_mem_read,
  input  logic [AW-1:0]          ex_mem_dest,
  input  logic                   mem_wb_reg_write,
  input  logic [AW-1:0]          mem_wb_dest,
  input  logic                   cnt_clr,
  output logic [2*NUM_SRC-1:0]   alu_fwd_sel,
  output logic [2*NUM_SRC-1:0]   cmp_fwd_sel,
  output logic                   stall,
  output logic                   bubble,
  output logic [CNT_W-1:0]       stall_cnt
);

  logic     w_m_id_ex  [NUM_SRC];
  logic     w_m_ex_mem [NUM_SRC];
  logic     w_m_mem_wb [NUM_SRC];
  fwd_sel_t w_alu_nxt  [NUM_SRC];
  fwd_sel_t w_cmp      [NUM_SRC];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_match #(.AW(AW)) u_match (
      .i_src              (id_src[s*AW +: AW]),
      .i_used             (id_src_used[s]),
      .i_id_ex_reg_write  (id_ex_reg_write),
      .i_id_ex_dest       (id_ex_dest),
      .i_ex_mem_reg_write (ex_mem_reg_write),
      .i_ex_mem_mem_read  (ex_mem_mem_read),
      .i_ex_mem_dest      (ex_mem_dest),
      .i_mem_wb_reg_write (mem_wb_reg_write),
      .i_mem_wb_dest      (mem_wb_dest),
      .o_m_id_ex          (w_m_id_ex[s]),
      .o_m_ex_mem         (w_m_ex_mem[s]),
      .o_m_mem_wb         (w_m_mem_wb[s]),
      .o_alu_sel_nxt      (w_alu_nxt[s]),
      .o_cmp_sel          (w_cmp[s])
    );
  end

  logic                 w_any_id_ex;
  logic                 w_any_ex_mem;
  logic                 w_hazard;
  logic [2*NUM_SRC-1:0] w_alu_nxt_vec;

  always_comb begin
    w_any_id_ex   = 1'b0;
    w_any_ex_mem  = 1'b0;
    w_alu_nxt_vec = '0;
    cmp_fwd_sel   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_any_id_ex           = w_any_id_ex  | w_m_id_ex[s];
      w_any_ex_mem          = w_any_ex_mem | w_m_ex_mem[s];
      w_alu_nxt_vec[2*s +: 2] = w_alu_nxt[s];
      cmp_fwd_sel[2*s +: 2]   = w_cmp[s];
    end
  end

  // Load-use, branch on an EX result, branch on a load still in MEM. A branch
  // after a load stalls twice purely because the load advances ID/EX -> EX/MEM.
  assign w_hazard = (id_ex_mem_read && w_any_id_ex)
                  | (id_is_branch && w_any_id_ex)
                  | (id_is_branch && ex_mem_mem_read && w_any_ex_mem);

  assign stall  = w_hazard && !flush;
  assign bubble = w_hazard || flush;

  logic [2*NUM_SRC-1:0] r_alu_fwd_sel;
  logic [CNT_W-1:0]     r_stall_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_fwd_sel <= '0;
    end else if (bubble) begin
      // The bubble entering ID/EX reads no sources.
      r_alu_fwd_sel <= '0;
    end else begin
      r_alu_fwd_sel <= w_alu_nxt_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign alu_fwd_sel = r_alu_fwd_sel;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default-width instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_fwd_hazard_unit;

  localparam int NUM_SRC = 2;
  localparam int AW      = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_SRC*AW-1:0] id_src;
  logic [NUM_SRC-1:0]    id_src_used;
  logic                  id_is_branch;
  logic                  flush;
  logic                  id_ex_reg_write;
  logic                  id_ex_mem_read;
  logic [AW-1:0]         id_ex_dest;
  logic                  ex_mem_reg_write;
  logic                  ex_mem_mem_read;
  logic [AW-1:0]         ex_mem_dest;
  logic                  mem_wb_reg_write;
  logic [AW-1:0]         mem_wb_dest;
  logic                  cnt_clr;

  logic [2*NUM_SRC-1:0]  alu_fwd_sel, alu_fwd_sel2;
  logic [2*NUM_SRC-1:0]  cmp_fwd_sel, cmp_fwd_sel2;
  logic                  stall, stall2;
  logic                  bubble, bubble2;
  logic [15:0]           stall_cnt;
  logic [1:0]            stall_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
    .id_is_branch(id_is_branch), .flush(flush),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read), .id_ex_dest(id_ex_dest),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dest(ex_mem_dest),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_dest(mem_wb_dest), .cnt_clr(cnt_clr),
    .alu_fwd_sel(alu_fwd_sel), .cmp_fwd_sel(cmp_fwd_sel), .stall(stall), .bubble(bubble),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
    .id_is_branch(id_is_branch), .flush(flush),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read), .id_ex_dest(id_ex_dest),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_dest(ex_mem_dest),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_dest(mem_wb_dest), .cnt_clr(cnt_clr),
    .alu_fwd_sel(alu_fwd_sel2), .cmp_fwd_sel(cmp_fwd_sel2), .stall(stall2), .bubble(bubble2),
    .stall_cnt(stall_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src = '0; id_src_used = '0; id_is_branch = 1'b0; flush = 1'b0;
    id_ex_reg_write = 1'b0; id_ex_mem_read = 1'b0; id_ex_dest = '0;
    ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_dest = '0;
    mem_wb_reg_write = 1'b0; mem_wb_dest = '0; cnt_clr = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("reset_alu", 32'(alu_fwd_sel), 32'h0);
    check("reset_cnt", 32'(stall_cnt), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: add r3 in ID/EX, ID reads rs=r3
    id_ex_reg_write = 1'b1; id_ex_dest = 5'd3;
    id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
    #1;
    check("t1_stall", 32'(stall), 32'h0);
    check("t1_bubble", 32'(bubble), 32'h0);
    step();
    check("t1_alu_exmem", 32'(alu_fwd_sel), 32'h2);

    // 2: lw r4 in ID/EX, ID reads rt=r4
    idle();
    id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_dest = 5'd4;
    id_src = {5'd4, 5'd0}; id_src_used = 2'b10;
    #1;
    check("t2_stall", 32'(stall), 32'h1);
    check("t2_bubble", 32'(bubble), 32'h1);
    step();
    check("t2_alu_bubble", 32'(alu_fwd_sel), 32'h0);
    id_ex_reg_write = 1'b0; id_ex_mem_read = 1'b0; id_ex_dest = '0;
    ex_mem_reg_write = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_dest = 5'd4;
    #1;
    check("t2_stall_released", 32'(stall), 32'h0);
    step();
    check("t2_alu_memwb", 32'(alu_fwd_sel), 32'h4);
    check("t2_cnt", 32'(stall_cnt), 32'h1);

    // 3: r0 producer never forwarded/stalled; unused source never forwarded
    idle();
    id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_dest = 5'd0;
    id_src = '0; id_src_used = 2'b11;
    #1;
    check("t3_r0_stall", 32'(stall), 32'h0);
    step();
    check("t3_r0_alu", 32'(alu_fwd_sel), 32'h0);
    id_ex_dest = 5'd7; id_src = {5'd7, 5'd7}; id_src_used = 2'b00;
    ex_mem_reg_write = 1'b1; ex_mem_dest = 5'd7; id_is_branch = 1'b1;
    #1;
    check("t3_unused_stall", 32'(stall), 32'h0);
    check("t3_unused_cmp", 32'(cmp_fwd_sel), 32'h0);
    step();
    check("t3_unused_alu", 32'(alu_fwd_sel), 32'h0);

    // 4a: beq on r5 after add r5 -> one stall, then compare from EX/MEM
    idle();
    id_is_branch = 1'b1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
    id_ex_reg_write = 1'b1; id_ex_dest = 5'd5;
    #1;
    check("t4a_stall", 32'(stall), 32'h1);
    step();
    id_ex_reg_write = 1'b0; id_ex_dest = '0;
    ex_mem_reg_write = 1'b1; ex_mem_dest = 5'd5;
    #1;
    check("t4a_stall_released", 32'(stall), 32'h0);
    check("t4a_cmp_exmem", 32'(cmp_fwd_sel), 32'h1);
    step();
    check("t4a_cnt", 32'(stall_cnt), 32'h2);
    idle();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t4_cnt_clr", 32'(stall_cnt), 32'h0);

    // 4b: beq on r5 after lw r5 -> two stalls, then compare from MEM/WB
    id_is_branch = 1'b1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
    id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_dest = 5'd5;
    #1;
    check("t4b_stall1", 32'(stall), 32'h1);
    step();
    id_ex_reg_write = 1'b0; id_ex_mem_read = 1'b0; id_ex_dest = '0;
    ex_mem_reg_write = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_dest = 5'd5;
    #1;
    check("t4b_stall2", 32'(stall), 32'h1);
    check("t4b_cmp_load_mem", 32'(cmp_fwd_sel), 32'h0);
    step();
    ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_dest = '0;
    mem_wb_reg_write = 1'b1; mem_wb_dest = 5'd5;
    #1;
    check("t4b_stall_released", 32'(stall), 32'h0);
    check("t4b_cmp_memwb", 32'(cmp_fwd_sel), 32'h2);
    check("t4b_cnt", 32'(stall_cnt), 32'h2);
    step();
    // MEM/WB producer alone: ALU reads write-through regfile
    check("t4b_alu_rf", 32'(alu_fwd_sel), 32'h0);

    // 5a: r6 produced by both ID/EX and EX/MEM -> youngest wins
    idle();
    id_src = {5'd6, 5'd0}; id_src_used = 2'b10;
    id_ex_reg_write = 1'b1; id_ex_dest = 5'd6;
    ex_mem_reg_write = 1'b1; ex_mem_dest = 5'd6;
    #1;
    check("t5a_cmp_exmem_rt", 32'(cmp_fwd_sel), 32'h4);
    step();
    check("t5a_alu_youngest", 32'(alu_fwd_sel), 32'h8);

    // 5b: flush over a load-use hazard
    id_ex_mem_read = 1'b1; flush = 1'b1;
    #1;
    check("t5b_stall", 32'(stall), 32'h0);
    check("t5b_bubble", 32'(bubble), 32'h1);
    step();
    check("t5b_alu", 32'(alu_fwd_sel), 32'h0);
    check("t5b_cnt", 32'(stall_cnt), 32'h2);

    // 6: saturation on the 2-bit counter, clear priority, async reset mid-stall
    idle();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_dest = 5'd9;
    id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
    for (int i = 0; i < 5; i++) step();
    check("t6_cnt16", 32'(stall_cnt), 32'h5);
    check("t6_cnt2_sat", 32'(stall_cnt2), 32'h3);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t6_clr_prio", 32'(stall_cnt), 32'h0);
    check("t6_clr_prio2", 32'(stall_cnt2), 32'h0);
    step();
    step();
    id_ex_mem_read = 1'b0; id_ex_dest = 5'd3; id_src = {5'd0, 5'd3};
    step();
    check("t6_pre_alu", 32'(alu_fwd_sel), 32'h2);
    check("t6_pre_cnt", 32'(stall_cnt), 32'h2);
    id_ex_mem_read = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_alu", 32'(alu_fwd_sel), 32'h0);
    check("t6_rst_cnt", 32'(stall_cnt), 32'h0);
    check("t6_rst_cnt2", 32'(stall_cnt2), 32'h0);
    check("t6_rst_stall_comb", 32'(stall), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
